spi_master_p: RTL and testbench
===============================

SPI_MASTER_P -- requirements
Module: spi_master_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8: frame width in bits, legal range 2..32.
REQ-002 SHALL have parameter DIV, default 12: sclk half-period in clk cycles, legal range 2..255.
REQ-003 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-004 SHALL have port n_rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: single-cycle request, already debounced and edge-detected upstream.
REQ-006 SHALL have port abort, input, 1: synchronous transfer cancel.
REQ-007 SHALL have port cpol, input, 1: clock idle level, sampled when start is accepted.
REQ-008 SHALL have port cpha, input, 1: 0 samples on the leading edge, 1 on the trailing edge; sampled when start is accepted.
REQ-009 SHALL have port tx_data, input, DATA_W: transmit word, sampled when start is accepted.
REQ-010 SHALL have port sdata, input, 1: serial data in from the slave (MISO).
REQ-011 SHALL have port sclk, output, 1: serial clock.
REQ-012 SHALL have port cs_n, output, 1: active-low chip select.
REQ-013 SHALL have port mosi, output, 1: serial data out to the slave.
REQ-014 SHALL have port rx_data, output, DATA_W: last completed receive word.
REQ-015 SHALL have port rx_valid, output, 1: one-cycle pulse when rx_data updates.
REQ-016 SHALL have port busy, output, 1: high from the cycle after start is accepted until the frame ends.

Function
REQ-017 SHALL implement states IDLE, SETUP, XFER, HOLD.
REQ-018 In IDLE, start is accepted when busy=0: latch tx_data, cpol, cpha; next state is SETUP.
REQ-019 SETUP SHALL last DIV cycles with cs_n=0 and sclk=cpol; when cpha=0, mosi presents the first bit from SETUP entry.
REQ-020 XFER SHALL last 2*DATA_W half-periods of DIV cycles each; sclk toggles at every half-period boundary, starting at XFER entry.
REQ-021 Sampling: sdata is shifted into the receive register on the sample edge (leading if cpha=0, trailing if cpha=1).
REQ-022 Shifting: mosi advances on the opposite edge; when cpha=1, the first bit appears on the first leading edge.
REQ-023 HOLD SHALL last DIV cycles with sclk=cpol and cs_n=0, then go to IDLE.
REQ-024 On the HOLD-to-IDLE transition, in the same cycle: cs_n=1, rx_data updates, rx_valid=1 for one cycle, busy=0.
REQ-025 Latency from start acceptance to rx_valid SHALL be exactly DIV*(2*DATA_W+2) cycles.
REQ-026 start while busy=1 SHALL be ignored and not queued.
REQ-027 start in the cycle rx_valid=1 SHALL be accepted, giving cs_n high for exactly one cycle between frames.
REQ-028 abort in any non-IDLE state: next cycle IDLE, cs_n=1, sclk=cpol, no rx_valid, rx_data unchanged.
REQ-029 abort and start in the same IDLE cycle: abort wins and start is ignored.
REQ-030 The half-period counter SHALL be $clog2(DIV) bits and wrap at DIV-1; the edge counter SHALL be $clog2(2*DATA_W)+1 bits.
REQ-031 cpol, cpha and tx_data changes during a frame SHALL have no effect on that frame.

Reset
REQ-032 On n_rst low, asynchronously: state=IDLE, sclk=0, cs_n=1, mosi=0, rx_data=0, rx_valid=0, busy=0, latched cpol/cpha=0.
REQ-033 Reset mid-frame SHALL release cs_n immediately, without waiting for a clk edge.

Configuration
REQ-034 With macro SPI_MASTER_P_LSB_FIRST_EN defined, bits SHALL be sent and received LSB first.
REQ-035 Without SPI_MASTER_P_LSB_FIRST_EN (default), bits SHALL be sent and received MSB first.
REQ-036 rx_data bit ordering SHALL always present the word in natural (non-reversed) order in both builds.

Structure
REQ-037 Package spi_pkg SHALL hold the state enum (IDLE/SETUP/XFER/HOLD) and the mode typedef {cpol, cpha}.
REQ-038 Sub-module spi_clk_gen SHALL generate half-period ticks and edge-type flags (leading/trailing) from DIV.
REQ-039 spi_master_p SHALL hold the FSM, shift registers and output registers.

Verification
REQ-040 Mode 0, DATA_W=8, DIV=12, tx_data=0xA5, slave returns 0x3C -> mosi shows 10100101 MSB-first; rx_data=0x3C; rx_valid exactly 216 cycles after start.
REQ-041 Modes 1, 2, 3 with the same data -> sclk idle level equals cpol; sample edges match REQ-021; rx_data=0x3C each time.
REQ-042 start pulsed again 50 cycles into a frame -> ignored; exactly one rx_valid; busy stays continuously high.
REQ-043 abort at cycle 100 of a frame -> cs_n=1 next cycle; no rx_valid; rx_data keeps its prior value 0x3C.
REQ-044 start asserted in the rx_valid cycle -> new frame begins; cs_n high for exactly 1 cycle between frames.
REQ-045 n_rst pulsed low mid-XFER -> cs_n=1 and sclk=0 asynchronously; LSB_FIRST_EN build with 0xA5 -> mosi 10100101 reversed (LSB first).

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding and per-frame clock mode.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StXfer,
    StHold
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Edge counter must hold the value 2*data_w itself, hence the extra bit.
  function automatic int unsigned edge_cnt_w(input int unsigned data_w);
    return $clog2(2 * data_w) + 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator with leading/trailing sclk edge flags for spi_master_p.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned DataW = 8,
  parameter int unsigned Div   = 12
) (
  input  logic clk,
  input  logic n_rst,
  input  logic run_i,
  input  logic edge_en_i,
  output logic tick_o,
  output logic edge_o,
  output logic lead_o,
  output logic trail_o,
  output logic last_o
);

  localparam int unsigned CntW  = $clog2(Div);
  localparam int unsigned EdgeW = edge_cnt_w(DataW);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [EdgeW-1:0] edge_cnt_q, edge_cnt_d;

  always_comb begin
    tick_o  = run_i && (cnt_q == CntW'(Div - 1));
    last_o  = (edge_cnt_q == EdgeW'(2 * DataW));
    edge_o  = tick_o && edge_en_i && !last_o;
    // Edges are numbered from 1; odd-numbered edges are leading.
    lead_o  = edge_o && !edge_cnt_q[0];
    trail_o = edge_o && edge_cnt_q[0];
  end

  always_comb begin
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    if (!run_i) begin
      cnt_d      = '0;
      edge_cnt_d = '0;
    end else begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      if (edge_o) begin
        edge_cnt_d = edge_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q      <= '0;
      edge_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_p.sv
// SPI master, single frame per start, modes 0-3 latched per frame.
// Build option: SPI_MASTER_P_LSB_FIRST_EN selects LSB-first bit order (default MSB first).
module spi_master_p
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV    = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              sdata,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

`ifdef SPI_MASTER_P_LSB_FIRST_EN
  localparam bit LsbFirst = 1'b1;
`else
  localparam bit LsbFirst = 1'b0;
`endif

  spi_state_e state_q, state_d;
  spi_mode_t  mode_q, mode_d;

  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              rx_valid_q, rx_valid_d;

  logic tick, sclk_edge, lead, trail, last_edge;
  logic accept, abort_now, frame_done, edge_en, sample_en, shift_en;

  function automatic logic out_bit(input logic [DATA_W-1:0] w);
    return LsbFirst ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return LsbFirst ? (w >> 1) : (w << 1);
  endfunction

  // Fill from the end opposite the first bit so the word lands in natural order.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return LsbFirst ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  spi_clk_gen #(
    .DataW(DATA_W),
    .Div  (DIV)
  ) u_clk_gen (
    .clk      (clk),
    .n_rst    (n_rst),
    .run_i    (busy),
    .edge_en_i(edge_en),
    .tick_o   (tick),
    .edge_o   (sclk_edge),
    .lead_o   (lead),
    .trail_o  (trail),
    .last_o   (last_edge)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && !abort) state_d = StSetup;
      StSetup: if (abort) state_d = StIdle; else if (tick) state_d = StXfer;
      StXfer:  if (abort) state_d = StIdle; else if (tick && last_edge) state_d = StHold;
      StHold:  if (abort || tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cs_n       = (state_q == StIdle);
    busy       = (state_q != StIdle);
    edge_en    = (state_q == StSetup) || (state_q == StXfer);
    accept     = (state_q == StIdle) && start && !abort;
    abort_now  = busy && abort;
    frame_done = (state_q == StHold) && tick && !abort;
    sample_en  = mode_q.cpha ? trail : lead;
    shift_en   = mode_q.cpha ? lead : trail;
  end

  always_comb begin
    mode_d     = mode_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    rx_valid_d = frame_done;
    if (accept) begin
      mode_d.cpol = cpol;
      mode_d.cpha = cpha;
      sclk_d      = cpol;
      // cpha=0 presents the first bit before the first edge; cpha=1 waits for it.
      if (cpha) begin
        tx_d = tx_data;
      end else begin
        mosi_d = out_bit(tx_data);
        tx_d   = shift_out(tx_data);
      end
    end else if (abort_now) begin
      sclk_d = mode_q.cpol;
    end else begin
      if (sclk_edge) sclk_d = ~sclk_q;
      if (shift_en) begin
        mosi_d = out_bit(tx_q);
        tx_d   = shift_out(tx_q);
      end
      if (sample_en) rx_sh_d = shift_in(rx_sh_q, sdata);
      if (frame_done) rx_data_d = rx_sh_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_q     <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_p.sv
// Directed bench for spi_master_p (DATA_W=8, DIV=12) with a behavioural SPI slave.
module tb_spi_master_p;

  localparam int FrameCyc = 216;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sdata = 1'b0;
  logic       sclk, cs_n, mosi, rx_valid, busy;
  logic [7:0] rx_data;

  int n_checks = 0;
  int n_fail = 0;

  spi_master_p #(
    .DATA_W(8),
    .DIV   (12)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .abort   (abort),
    .cpol    (cpol),
    .cpha    (cpha),
    .tx_data (tx_data),
    .sdata   (sdata),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout, required normal end");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural slave: returns slv_word, assembles the mosi word in natural order.
  logic       slv_cpha = 1'b0;
  logic [7:0] slv_word = 8'h00;
  logic [7:0] slv_rx = 8'h00;
  int         slv_edges = 0;
  int         slv_nbits = 0;
  logic       slv_prev_sclk = 1'b0;
  logic       slv_prev_cs = 1'b1;
  logic       slv_lead = 1'b0;

  function automatic logic slv_bit(input logic [7:0] w, input int i);
`ifdef SPI_MASTER_P_LSB_FIRST_EN
    return w[i];
`else
    return w[7-i];
`endif
  endfunction

  always @(negedge clk) begin
    if (cs_n) begin
      slv_edges = 0;
    end else if (slv_prev_cs) begin
      slv_edges     = 0;
      slv_nbits     = 0;
      slv_rx        = 8'h00;
      slv_prev_sclk = sclk;
      if (!slv_cpha) sdata = slv_bit(slv_word, 0);
    end else if (sclk != slv_prev_sclk) begin
      slv_edges++;
      slv_prev_sclk = sclk;
      slv_lead      = (slv_edges % 2) == 1;
      if (slv_lead != slv_cpha && slv_nbits < 8) begin
`ifdef SPI_MASTER_P_LSB_FIRST_EN
        slv_rx[slv_nbits] = mosi;
`else
        slv_rx = {slv_rx[6:0], mosi};
`endif
        slv_nbits++;
      end
      if (slv_cpha && slv_lead) sdata = slv_bit(slv_word, (slv_edges - 1) / 2);
      if (!slv_cpha && !slv_lead && slv_edges / 2 < 8) sdata = slv_bit(slv_word, slv_edges / 2);
    end
    slv_prev_cs = cs_n;
  end

  // Runs one frame; optionally re-pulses start and scrambles inputs at cycle restart_at.
  task automatic do_frame(input logic pol, input logic pha, input logic [7:0] tx,
                          input logic [7:0] sw, input int restart_at, output int lat,
                          output int nvalid, output int gaps);
    @(posedge clk); #1;
    cpol = pol; cpha = pha; tx_data = tx; slv_cpha = pha; slv_word = sw; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("setup_cs_n", 32'(cs_n), 32'(0));
    chk("setup_sclk", 32'(sclk), 32'(pol));
    chk("setup_busy", 32'(busy), 32'(1));
    lat = -1; nvalid = 0; gaps = 0;
    for (int cyc = 1; cyc <= FrameCyc + 20; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (rx_valid) begin
        nvalid++;
        if (lat < 0) lat = cyc;
      end
      if (lat < 0 && !busy) gaps++;
      if (cyc == restart_at) begin
        start = 1'b1; tx_data = ~tx; cpol = ~pol; cpha = ~pha;
      end
    end
  endtask

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] tx;
    logic [7:0] slv;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, nv, gaps;
    vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[1] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[2] = '{1'b1, 1'b0, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[3] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[4] = '{1'b0, 1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81};
    vecs[5] = '{1'b1, 1'b0, 8'h4B, 8'hD2, 8'hD2, 8'h4B};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(cs_n), 32'(1));
    chk("rst_sclk", 32'(sclk), 32'(0));
    chk("rst_mosi", 32'(mosi), 32'(0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    n_rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_cs_n", 32'(cs_n), 32'(1));

    for (int i = 0; i < 6; i++) begin
      do_frame(vecs[i].cpol, vecs[i].cpha, vecs[i].tx, vecs[i].slv, -1, lat, nv, gaps);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(FrameCyc));
      chk($sformatf("v%0d_nvalid", i), 32'(nv), 32'(1));
      chk($sformatf("v%0d_busy_gaps", i), 32'(gaps), 32'(0));
      chk($sformatf("v%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
      chk($sformatf("v%0d_mosi_word", i), 32'(slv_rx), 32'(vecs[i].exp_mosi));
      chk($sformatf("v%0d_sclk_idle", i), 32'(sclk), 32'(vecs[i].cpol));
      chk($sformatf("v%0d_cs_n_idle", i), 32'(cs_n), 32'(1));
    end

    // Second start mid-frame, with mode/data changes, must not disturb the frame.
    do_frame(1'b0, 1'b0, 8'hA5, 8'h3C, 50, lat, nv, gaps);
    chk("restart_latency", 32'(lat), 32'(FrameCyc));
    chk("restart_nvalid", 32'(nv), 32'(1));
    chk("restart_busy_gaps", 32'(gaps), 32'(0));
    chk("restart_rx_data", 32'(rx_data), 32'(8'h3C));
    chk("restart_mosi_word", 32'(slv_rx), 32'(8'hA5));

    // Abort at cycle 100.
    @(posedge clk); #1;
    cpol = 1'b1; cpha = 1'b0; tx_data = 8'hA5; slv_cpha = 1'b0; slv_word = 8'h99; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_cs_n", 32'(cs_n), 32'(1));
    chk("abort_sclk", 32'(sclk), 32'(1));
    chk("abort_busy", 32'(busy), 32'(0));
    nv = 0;
    for (int c = 0; c < 250; c++) begin
      @(posedge clk); #1;
      if (rx_valid) nv++;
    end
    chk("abort_nvalid", 32'(nv), 32'(0));
    chk("abort_rx_data", 32'(rx_data), 32'(8'h3C));

    // Back-to-back frames: start in the rx_valid cycle.
    @(posedge clk); #1;
    cpol = 1'b0; cpha = 1'b0; tx_data = 8'h3C; slv_cpha = 1'b0; slv_word = 8'hA5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= FrameCyc + 20; c++) begin
      @(posedge clk); #1;
      if (rx_valid) begin
        lat = c;
        break;
      end
    end
    chk("b2b_first_latency", 32'(lat), 32'(FrameCyc));
    chk("b2b_gap_cs_n", 32'(cs_n), 32'(1));
    chk("b2b_first_rx", 32'(rx_data), 32'(8'hA5));
    chk("b2b_first_mosi", 32'(slv_rx), 32'(8'h3C));
    tx_data = 8'hC3; slv_word = 8'h5A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_second_cs_n", 32'(cs_n), 32'(0));
    chk("b2b_second_busy", 32'(busy), 32'(1));
    lat = -1;
    for (int c = 1; c <= FrameCyc + 20; c++) begin
      @(posedge clk); #1;
      if (rx_valid) begin
        lat = c;
        break;
      end
    end
    chk("b2b_second_latency", 32'(lat), 32'(FrameCyc));
    chk("b2b_second_rx", 32'(rx_data), 32'(8'h5A));
    chk("b2b_second_mosi", 32'(slv_rx), 32'(8'hC3));

    // start and abort together in IDLE: abort wins.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'(0));
    chk("start_abort_cs_n", 32'(cs_n), 32'(1));

    // Asynchronous reset mid-XFER with sclk high.
    @(posedge clk); #1;
    cpol = 1'b1; cpha = 1'b1; tx_data = 8'hA5; slv_cpha = 1'b1; slv_word = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("pre_rst_sclk", 32'(sclk), 32'(1));
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst_cs_n", 32'(cs_n), 32'(1));
    chk("async_rst_sclk", 32'(sclk), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_rx_data", 32'(rx_data), 32'(0));
    @(posedge clk); #1;
    n_rst = 1'b1;

    do_frame(1'b0, 1'b0, 8'hA5, 8'h3C, -1, lat, nv, gaps);
    chk("post_rst_latency", 32'(lat), 32'(FrameCyc));
    chk("post_rst_rx_data", 32'(rx_data), 32'(8'h3C));
    chk("post_rst_mosi_word", 32'(slv_rx), 32'(8'hA5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
